// File: rtl/apb_stepper_pulse_gen.sv
// apb_stepper_pulse_gen: APB3 slave that turns firmware-programmed moves into
// STEP/DIR/ENABLE for one stepper-driver axis, keeps absolute position and
// raises a level interrupt when a move finishes or is aborted.
module apb_stepper_pulse_gen #(
  parameter int PULSE_W   = 100,
  parameter int SETUP_CYC = 50,
  parameter int CNT_W     = 16
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [4:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        STEP,
  output logic        DIR,
  output logic        EN_N,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_STEPS  = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_POS    = 3'd4;

  // Shortest legal period: STEP high for PULSE_W and low for at least PULSE_W.
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2 * PULSE_W);
  localparam logic [CNT_W-1:0] PULSE_LEN  = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] low_last_q, low_last_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      position_q, position_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             abort_pend_q, abort_pend_d;

  logic             en_q, en_d;
  logic             dir_req_q, dir_req_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             irq_q, irq_d;

  logic             busy;
  logic             access;
  logic             wr_err;
  logic             wr_ok;
  logic [2:0]       reg_sel;
  logic             wr_ctrl, wr_period, wr_steps, wr_status, wr_pos;
  logic             abort_req;
  logic             set_done, set_aborted;
  logic [CNT_W-1:0] eff_period;
  logic [CNT_W-1:0] new_steps;
  logic             unused_addr;

  assign reg_sel     = PADDR[4:2];
  assign unused_addr = ^PADDR[1:0];
  assign busy        = (state_q != S_IDLE);
  assign access      = PSEL & PENABLE;
  assign new_steps   = PWDATA[CNT_W-1:0];

  // Moves can only be started from idle with the driver enabled, and position
  // may not be overwritten while the motor is moving.
  assign wr_err  = ((reg_sel == A_STEPS) && (busy || !en_q)) ||
                   ((reg_sel == A_POS) && busy);
  assign wr_ok   = access & PWRITE & ~wr_err;
  assign PSLVERR = access & PWRITE & wr_err;
  assign PREADY  = 1'b1;

  assign wr_ctrl   = wr_ok && (reg_sel == A_CTRL);
  assign wr_period = wr_ok && (reg_sel == A_PERIOD);
  assign wr_steps  = wr_ok && (reg_sel == A_STEPS);
  assign wr_status = wr_ok && (reg_sel == A_STATUS);
  assign wr_pos    = wr_ok && (reg_sel == A_POS);

  // An explicit ABORT pulse or dropping EN during a move both stop it.
  assign abort_req = busy & ((wr_ctrl & (PWDATA[3] | ~PWDATA[0])) | ~en_q);

  assign eff_period = (period_q < MIN_PERIOD) ? MIN_PERIOD : period_q;

  assign STEP = step_q;
  assign DIR  = dir_q;
  assign EN_N = ~en_q;
  assign IRQ  = irq_q;

  // Move sequencer: setup delay, then alternating high/low phases per step.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    low_last_d   = low_last_q;
    remaining_d  = remaining_q;
    position_d   = position_q;
    dir_d        = dir_q;
    abort_pend_d = abort_pend_q;
    set_done     = 1'b0;
    set_aborted  = 1'b0;

    if (wr_pos) begin
      position_d = PWDATA;
    end

    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (wr_steps) begin
          remaining_d = new_steps;
          if (new_steps != '0) begin
            dir_d      = dir_req_q;
            low_last_d = eff_period - PULSE_LEN - ONE;
            cnt_d      = SETUP_LAST;
            state_d    = S_SETUP;
          end else begin
            set_done = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (abort_req) begin
          state_d     = S_IDLE;
          set_aborted = 1'b1;
        end else if (cnt_q == '0) begin
          state_d     = S_HIGH;
          cnt_d       = PULSE_LAST;
          remaining_d = remaining_q - ONE;
          position_d  = dir_q ? (position_q + 32'd1) : (position_q - 32'd1);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      S_HIGH: begin
        if (abort_req) begin
          abort_pend_d = 1'b1;
        end
        if (cnt_q == '0) begin
          if (abort_pend_q || abort_req) begin
            state_d     = S_IDLE;
            set_aborted = 1'b1;
          end else begin
            state_d = S_LOW;
            cnt_d   = low_last_q;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      S_LOW: begin
        if ((cnt_q == '0) && (remaining_q == '0)) begin
          state_d  = S_IDLE;
          set_done = 1'b1;
        end else if (abort_req) begin
          state_d     = S_IDLE;
          set_aborted = 1'b1;
        end else if (cnt_q == '0) begin
          state_d     = S_HIGH;
          cnt_d       = PULSE_LAST;
          remaining_d = remaining_q - ONE;
          position_d  = dir_q ? (position_q + 32'd1) : (position_q - 32'd1);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    step_d = (state_d == S_HIGH);
  end

  // Control/status registers; a status set event beats a same-cycle W1C.
  always_comb begin
    en_d      = en_q;
    dir_req_d = dir_req_q;
    irq_en_d  = irq_en_q;
    period_d  = period_q;

    if (wr_ctrl) begin
      en_d      = PWDATA[0];
      dir_req_d = PWDATA[1];
      irq_en_d  = PWDATA[2];
    end
    if (wr_period) begin
      period_d = PWDATA[CNT_W-1:0];
    end

    done_d    = set_done    | (done_q    & ~(wr_status & PWDATA[1]));
    aborted_d = set_aborted | (aborted_q & ~(wr_status & PWDATA[2]));
    irq_d     = irq_en_q & (done_q | aborted_q);
  end

  // Read mux; returns zero whenever the slave is not selected.
  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (reg_sel)
        A_CTRL:   PRDATA = {29'd0, irq_en_q, dir_req_q, en_q};
        A_PERIOD: PRDATA[CNT_W-1:0] = period_q;
        A_STEPS:  PRDATA[CNT_W-1:0] = remaining_q;
        A_STATUS: PRDATA = {29'd0, aborted_q, done_q, busy};
        A_POS:    PRDATA = position_q;
        default:  PRDATA = '0;
      endcase
    end
  end

  // All state updates on PCLK; reset wipes any move in flight immediately.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      low_last_q   <= '0;
      remaining_q  <= '0;
      position_q   <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      en_q         <= 1'b0;
      dir_req_q    <= 1'b0;
      irq_en_q     <= 1'b0;
      period_q     <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      low_last_q   <= low_last_d;
      remaining_q  <= remaining_d;
      position_q   <= position_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      abort_pend_q <= abort_pend_d;
      en_q         <= en_d;
      dir_req_q    <= dir_req_d;
      irq_en_q     <= irq_en_d;
      period_q     <= period_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      irq_q        <= irq_d;
    end
  end

endmodule
